// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial word receiver: byte FSM states,
// word assembler phases and the 25 MHz / 115200 baud bit period.
package serial_pkg;

  localparam int CLKS_PER_BIT_25M = 217;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } asm_phase_e;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF input synchroniser, bit timer and byte FSM.
// Emits one-cycle byte_done / frame_err pulses and reports when it is idle.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RX_IDLE  | line idle, waiting for a falling edge on rx_s
//   RX_START | half-bit wait, then confirm the start bit is still low
//   RX_DATA  | sample 8 data bits LSB first, one per bit period
//   RX_STOP  | sample the stop bit; 1 -> byte_done, 0 -> frame_err
//   RX_BREAK | stop bit was low; wait for the line to return high
module uart_rx_byte
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_25M
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frame_err,
  output logic       rx_idle
);

  localparam int BIT_W = cnt_width(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] HALF_LOAD = BIT_W'(CLKS_PER_BIT / 2);
  localparam logic [BIT_W-1:0] FULL_LOAD = BIT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q;
  logic             rx_s_q;
  rx_state_e        state_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             byte_done_q;
  logic             frame_err_q;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!rx_s_q) begin
            state_q   <= RX_START;
            bit_cnt_q <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (bit_cnt_q == '0) begin
            if (!rx_s_q) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= FULL_LOAD;
              bit_idx_q <= '0;
            end else begin
              state_q <= RX_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
          end
        end
        RX_DATA: begin
          if (bit_cnt_q == '0) begin
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_cnt_q <= FULL_LOAD;
            if (bit_idx_q == 3'd7) begin
              state_q <= RX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
          end
        end
        RX_STOP: begin
          if (bit_cnt_q == '0) begin
            if (rx_s_q) begin
              byte_done_q <= 1'b1;
              state_q     <= RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RX_BREAK;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
          end
        end
        RX_BREAK: begin
          if (rx_s_q) begin
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_byte   = shift_q;
  assign byte_done = byte_done_q;
  assign frame_err = frame_err_q;
  assign rx_idle   = (state_q == RX_IDLE);

endmodule

// File: rtl/serial_word_receiver.sv
// UART receive front end: pairs received bytes into 16-bit words (low byte
// first) and buffers them in a first-word-fall-through FIFO for the CPU.
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_25M,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RxD,
  input  logic        Read,
  output logic [15:0] DataOut,
  output logic        Valid,
  output logic        Overrun,
  output logic        FrameError
);

  localparam int PTR_W    = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = cnt_width(TO_LIMIT - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TO_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       byte_done;
  logic       frame_err;
  logic       rx_idle;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (Clock),
    .rst_n     (Reset),
    .rxd       (RxD),
    .rx_byte   (rx_byte),
    .byte_done (byte_done),
    .frame_err (frame_err),
    .rx_idle   (rx_idle)
  );

  asm_phase_e      phase_q, phase_d;
  logic [7:0]      low_q, low_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            push;
  logic [15:0]     push_word;

  // Timeout down-counter only runs while a low byte is held and the line is idle.
  always_comb begin
    phase_d   = phase_q;
    low_d     = low_q;
    to_cnt_d  = TO_LOAD;
    push      = 1'b0;
    push_word = {rx_byte, low_q};
    if (frame_err) begin
      phase_d = PH_LOW;
      low_d   = '0;
    end else if (byte_done) begin
      if (phase_q == PH_LOW) begin
        low_d   = rx_byte;
        phase_d = PH_HIGH;
      end else begin
        push    = 1'b1;
        phase_d = PH_LOW;
        low_d   = '0;
      end
    end else if ((phase_q == PH_HIGH) && rx_idle) begin
      if (to_cnt_q == '0) begin
        phase_d = PH_LOW;
        low_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q - TO_W'(1);
      end
    end
  end

  logic [15:0]      mem_q [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             drop;

  always_comb begin
    pop        = Read && valid_q;
    full       = (count_q == CNT_FULL);
    push_ok    = push && (!full || pop);
    drop       = push && full && !pop;
    rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    rd_ptr_d   = pop ? rd_ptr_nxt : rd_ptr_q;
    wr_ptr_d   = push_ok ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    valid_d    = (count_d != '0);

    // Head register: next stored word on a pop, or the incoming word if it lands in an empty slot.
    data_out_d = data_out_q;
    if (pop) begin
      if (count_q > CNT_W'(1)) begin
        data_out_d = mem_q[rd_ptr_nxt];
      end else if (push_ok) begin
        data_out_d = push_word;
      end
    end else if ((count_q == '0) && push_ok) begin
      data_out_d = push_word;
    end

    overrun_d = overrun_q;
    if (pop) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      phase_q    <= PH_LOW;
      low_q      <= '0;
      to_cnt_q   <= TO_LOAD;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      low_q      <= low_d;
      to_cnt_q   <= to_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign DataOut    = data_out_q;
  assign Valid      = valid_q;
  assign Overrun    = overrun_q;
  assign FrameError = frame_err;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed plus randomized bench for serial_word_receiver; expected words come
// from a queue model of the word stream and FIFO.
module tb_serial_word_receiver;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int TOB   = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd   = 1'b1;
  logic        rd    = 1'b0;
  logic [15:0] dout;
  logic        valid;
  logic        ovr;
  logic        fe;

  always #5 clk = ~clk;

  serial_word_receiver #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .Clock      (clk),
    .Reset      (rst_n),
    .RxD        (rxd),
    .Read       (rd),
    .DataOut    (dout),
    .Valid      (valid),
    .Overrun    (ovr),
    .FrameError (fe)
  );

  int n_cmp     = 0;
  int n_bad     = 0;
  int cyc       = 0;
  int fe_cycles = 0;

  logic [15:0] exp_q[$];
  logic        exp_ovr   = 1'b0;
  logic [15:0] last_word = 16'h0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (fe === 1'b1) fe_cycles++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop_bit;
    idle(CPB);
    rxd = 1'b1;
  endtask

  task automatic model_push(input logic [15:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else exp_ovr = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[7:0], 1'b1);
    idle(gap);
    send_byte(w[15:8], 1'b1);
    idle(4);
    model_push(w);
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() > 0) begin
      chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
      chk({tag, "_data"}, {16'b0, dout}, {16'b0, exp_q[0]});
      chk({tag, "_ovr"}, {31'b0, ovr}, {31'b0, exp_ovr});
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      last_word = exp_q.pop_front();
      exp_ovr   = 1'b0;
    end else begin
      chk({tag, "_empty_valid"}, {31'b0, valid}, 32'd0);
      chk({tag, "_empty_hold"}, {16'b0, dout}, {16'b0, last_word});
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      chk({tag, "_rd_empty_valid"}, {31'b0, valid}, 32'd0);
      chk({tag, "_rd_empty_hold"}, {16'b0, dout}, {16'b0, last_word});
    end
  endtask

  initial begin
    int c0;
    int lat;
    int k;
    int fe0;
    logic [15:0] w;

    rst_n = 1'b0;
    idle(3);
    chk("rst_dout", {16'b0, dout}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_ovr", {31'b0, ovr}, 32'd0);
    chk("rst_fe", {31'b0, fe}, 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Basic word with latency window: stop sample ~79 cycles after the start edge, Valid ~2 later.
    send_byte(8'h34, 1'b1);
    idle(2);
    c0 = cyc;
    send_byte(8'h12, 1'b1);
    k = 0;
    while (valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    lat = cyc - c0;
    chk("latency_window", {31'b0, (lat >= 78 && lat <= 84)}, 32'd1);
    idle(2);
    model_push(16'h1234);
    pop_chk("w1234");
    pop_chk("w1234_after");

    // Start glitch shorter than half a bit is ignored silently.
    fe0 = fe_cycles;
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(20);
    send_word(16'hABCD, 3);
    chk("glitch_no_fe", fe_cycles - fe0, 32'd0);
    pop_chk("wabcd");
    pop_chk("wabcd_after");

    // Framing error drops the held low byte and pulses FrameError for one cycle.
    fe0 = fe_cycles;
    send_byte(8'h55, 1'b1);
    idle(2);
    send_byte(8'($urandom), 1'b0);
    idle(20);
    chk("fe_one_pulse", fe_cycles - fe0, 32'd1);
    send_word(16'h2211, 1);
    pop_chk("w2211");
    pop_chk("w2211_after");

    // Overrun: six words into a four-deep FIFO.
    for (int i = 1; i <= 6; i++) send_word(16'(i), $urandom_range(0, 5));
    chk("overrun_set", {31'b0, ovr}, {31'b0, exp_ovr});
    for (int i = 0; i < 4; i++) pop_chk("ovr_pop");
    pop_chk("ovr_drained");

    // Inter-byte timeout discards the held low byte.
    send_byte(8'h77, 1'b1);
    idle(40);
    send_word(16'h9988, 2);
    pop_chk("w9988");
    pop_chk("w9988_after");

    // Reset in the DATA state of a high byte with the FIFO full and overrun set.
    for (int i = 0; i < 5; i++) send_word(16'($urandom), $urandom_range(0, 5));
    chk("pre_rst_ovr", {31'b0, ovr}, 32'd1);
    send_byte(8'hA5, 1'b1);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rxd = i[0];
      idle(CPB);
    end
    rst_n = 1'b0;
    rxd   = 1'b1;
    @(negedge clk);
    chk("mid_rst_dout", {16'b0, dout}, 32'd0);
    chk("mid_rst_valid", {31'b0, valid}, 32'd0);
    chk("mid_rst_ovr", {31'b0, ovr}, 32'd0);
    chk("mid_rst_fe", {31'b0, fe}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    exp_q.delete();
    exp_ovr   = 1'b0;
    last_word = 16'h0;
    idle(5);
    send_word(16'hBEEF, 2);
    pop_chk("wbeef");
    pop_chk("wbeef_after");

    // Randomized traffic with random pops against the queue model.
    for (int it = 0; it < 25; it++) begin
      w = 16'($urandom);
      send_word(w, $urandom_range(0, 6));
      idle($urandom_range(0, 20));
      repeat ($urandom_range(0, 2)) pop_chk("rnd_pop");
    end
    while (exp_q.size() > 0) pop_chk("rnd_drain");
    pop_chk("rnd_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
